// File: rtl/cda_n_cntr_monitor.sv
// Lock monitor for the PLL N-counter output: measures the high and low phase lengths
// of the synchronised divided clock and declares lock after LOCK_COUNT good periods.
module cda_n_cntr_monitor #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_half,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic             meas_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ALIGN, MEAS_HI, MEAS_LO} state_e;

  logic s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = div_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      // Shift toward the MSB; the cast drops the oldest bit so one stage works too.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= SYNC_STAGES'({sync_q, div_in});
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  state_e           state_q, state_d;
  logic             d_q;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d;
  logic [CNT_W-1:0] meas_high_q, meas_high_d, meas_low_q, meas_low_d;
  logic             valid_q, valid_d, locked_q, locked_d;
  logic             mismatch_q, mismatch_d, timeout_q, timeout_d;
  logic             rise, fall, match;

  assign rise  = s & ~d_q;
  assign fall  = ~s & d_q;
  assign match = (exp_half != '0) && (hcnt_q == exp_half) && (lcnt_q == exp_half);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      d_q         <= 1'b0;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      mcnt_q      <= '0;
      meas_high_q <= '0;
      meas_low_q  <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= s;
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      mcnt_q      <= mcnt_d;
      meas_high_q <= meas_high_d;
      meas_low_q  <= meas_low_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      mismatch_q  <= mismatch_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    mcnt_d      = mcnt_q;
    meas_high_d = meas_high_q;
    meas_low_d  = meas_low_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    mismatch_d  = 1'b0;
    timeout_d   = 1'b0;

    if (!enable) begin
      // Disable overrides everything, including a close or saturation this cycle.
      state_d  = IDLE;
      hcnt_d   = '0;
      lcnt_d   = '0;
      mcnt_d   = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = ALIGN;
        ALIGN: begin
          if (rise) begin
            state_d = MEAS_HI;
            hcnt_d  = CNT_W'(1);
          end
        end
        MEAS_HI: begin
          if (fall) begin
            state_d = MEAS_LO;
            lcnt_d  = CNT_W'(1);
          end else if (hcnt_q == CNT_MAX) begin
            state_d   = ALIGN;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            mcnt_d    = '0;
            hcnt_d    = '0;
            lcnt_d    = '0;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end
        MEAS_LO: begin
          if (rise) begin
            // Closing rise: report the finished period and start the next one.
            state_d     = MEAS_HI;
            hcnt_d      = CNT_W'(1);
            meas_high_d = hcnt_q;
            meas_low_d  = lcnt_q;
            valid_d     = 1'b1;
            if (match) begin
              mcnt_d   = (mcnt_q == LOCK_C) ? mcnt_q : mcnt_q + 1'b1;
              locked_d = (mcnt_d == LOCK_C);
            end else begin
              mcnt_d     = '0;
              locked_d   = 1'b0;
              mismatch_d = (exp_half != '0);
            end
          end else if (lcnt_q == CNT_MAX) begin
            state_d   = ALIGN;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            mcnt_d    = '0;
            hcnt_d    = '0;
            lcnt_d    = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign meas_high  = meas_high_q;
  assign meas_low   = meas_low_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign mismatch   = mismatch_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_cda_n_cntr_monitor.sv
// Bench for cda_n_cntr_monitor: drives div_in as lists of (high, low) periods and checks
// every reported period, lock/mismatch flags and pulse spacing against a period-level model.
module tb_cda_n_cntr_monitor;
  localparam int CW   = 4;
  localparam int SYNC = 2;
  localparam int LOCK = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          div_in = 1'b0;
  logic [CW-1:0] exp_half = '0;
  logic [CW-1:0] meas_high, meas_low;
  logic          meas_valid, locked, mismatch, timeout;

  cda_n_cntr_monitor #(.CNT_W(CW), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCK)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .div_in(div_in),
    .exp_half(exp_half), .meas_high(meas_high), .meas_low(meas_low),
    .meas_valid(meas_valid), .locked(locked), .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0, stray = 0, to_cnt = 0, to_cyc = 0;
  int ph[$], pl[$], pm[$], pk[$], pc[$];
  int hq[$], lq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every reported period; outputs are sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (meas_valid) begin
        ph.push_back(int'(meas_high));
        pl.push_back(int'(meas_low));
        pm.push_back(int'(mismatch));
        pk.push_back(int'(locked));
        pc.push_back(cyc);
      end
      if (mismatch && !meas_valid) stray++;
      if (timeout) begin
        to_cnt++;
        to_cyc = cyc;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    div_in = v;
    repeat (n) tick();
  endtask

  task automatic add_period(input int h, input int l);
    hq.push_back(h);
    lq.push_back(l);
  endtask

  // Enable, discard-align on a low stretch, play the queued periods, then close the last
  // one with a final rise. Each period is reported once, at the rise that ends it.
  task automatic run(input int e, input bit keep_en, input string tag);
    int streak = 0;
    int n = hq.size();
    int to0 = to_cnt;
    int st0 = stray;
    bit m;
    ph.delete(); pl.delete(); pm.delete(); pk.delete(); pc.delete();
    exp_half = CW'(e);
    enable = 1'b1;
    drive(1'b0, 6);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, hq[i]);
      drive(1'b0, lq[i]);
    end
    drive(1'b1, SYNC + 4);
    $display("run %s exp_half=%0d periods=%0d pulses=%0d", tag, e, n, ph.size());
    check($sformatf("%s_count", tag), ph.size(), n);
    for (int i = 0; i < n && i < ph.size(); i++) begin
      m = (e != 0) && (hq[i] == e) && (lq[i] == e);
      streak = m ? ((streak < LOCK) ? streak + 1 : LOCK) : 0;
      check($sformatf("%s_high%0d", tag, i), ph[i], hq[i]);
      check($sformatf("%s_low%0d", tag, i), pl[i], lq[i]);
      check($sformatf("%s_mism%0d", tag, i), pm[i], int'((e != 0) && !m));
      check($sformatf("%s_lock%0d", tag, i), pk[i], int'(streak == LOCK));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), pc[i] - pc[i-1], hq[i] + lq[i]);
    end
    check($sformatf("%s_stray", tag), stray - st0, 0);
    check($sformatf("%s_noto", tag), to_cnt - to0, 0);
    if (!keep_en) begin
      int np;
      enable = 1'b0;
      tick();
      @(negedge clk);
      check($sformatf("%s_dis_lock", tag), int'(locked), 0);
      np = ph.size();
      repeat (4) tick();
      check($sformatf("%s_dis_quiet", tag), ph.size() + (stray - st0) + (to_cnt - to0), np);
      div_in = 1'b0;
    end
    hq.delete();
    lq.delete();
  endtask

  initial begin
    int e, n, h, l, w, to0, vcyc;

    repeat (3) tick();
    check("rst_meas_high", int'(meas_high), 0);
    check("rst_meas_low", int'(meas_low), 0);
    check("rst_flags", int'({meas_valid, locked, mismatch, timeout}), 0);
    reset_n = 1'b1;
    tick();

    // Steady 3/3 clock, lock on the 4th period, then disable while locked.
    repeat (6) add_period(3, 3);
    run(3, 1'b0, "t1");

    // One long-high period breaks lock; four good ones restore it.
    repeat (5) add_period(3, 3);
    add_period(4, 3);
    repeat (5) add_period(3, 3);
    run(3, 1'b0, "t2");

    // Compare disabled.
    repeat (4) add_period(5, 5);
    run(0, 1'b0, "t6");

    // Single-cycle phases.
    repeat (5) add_period(1, 1);
    run(1, 1'b0, "glitch1");
    add_period(3, 3); add_period(1, 3); add_period(3, 1); add_period(3, 3);
    run(3, 1'b0, "glitch3");

    // Lock, then hold div_in high until the high-phase counter saturates.
    repeat (6) add_period(3, 3);
    run(3, 1'b1, "t3pre");
    vcyc = (pc.size() > 0) ? pc[pc.size()-1] : 0;
    to0 = to_cnt;
    w = 0;
    while (to_cnt == to0 && w < 40) begin
      tick();
      w++;
    end
    check("t3_timeout_seen", to_cnt - to0, 1);
    check("t3_timeout_when", to_cyc - vcyc, (1 << CW) - 1);
    @(negedge clk);
    check("t3_lock_clear", int'(locked), 0);
    check("t3_meas_high_held", int'(meas_high), 3);
    check("t3_meas_low_held", int'(meas_low), 3);
    check("t3_no_valid", ph.size(), 6);
    repeat (5) add_period(3, 3);
    run(3, 1'b0, "t3post");

    // Reset in the middle of a low phase.
    repeat (5) add_period(3, 3);
    run(3, 1'b1, "t4pre");
    drive(1'b0, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_rst_meas_high", int'(meas_high), 0);
    check("t4_rst_meas_low", int'(meas_low), 0);
    check("t4_rst_flags", int'({meas_valid, locked, mismatch, timeout}), 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) add_period(3, 3);
    add_period(2, 5);
    repeat (2) add_period(3, 3);
    run(3, 1'b0, "t4post");

    // Random period lists, mostly on-target so lock is reached regularly.
    for (int r = 0; r < 6; r++) begin
      e = $urandom_range(0, 6);
      n = $urandom_range(4, 10);
      for (int i = 0; i < n; i++) begin
        if (e != 0 && $urandom_range(0, 99) < 65) begin
          h = e;
          l = e;
        end else begin
          h = $urandom_range(1, 8);
          l = $urandom_range(1, 8);
        end
        add_period(h, l);
      end
      run(e, 1'b0, $sformatf("rnd%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
